// File: rtl/irqc_pkg.sv
// Shared types and register-window addresses for the interrupt controller.
package irqc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

    localparam logic [1:0] ADDR_PENDING = 2'd0;
    localparam logic [1:0] ADDR_MASK    = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_COMPARE = 2'd3;

endpackage

// File: rtl/prio_enc.sv
// Fixed-priority encoder: the lowest set request index wins.
module prio_enc #(
    parameter int unsigned N  = 8,
    parameter int unsigned IW = 3
) (
    input  logic [N-1:0]  req_i,
    output logic          valid_o,
    output logic [IW-1:0] idx_o
);

    // Scan downward so the last hit written is the lowest index.
    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = IW'(i);
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Edge-capturing, maskable, fixed-priority interrupt sequencer feeding cp0.
// Optional compare timer on source 0 is built when IRQC_TIMER_EN is defined.
module irq_controller
    import irqc_pkg::*;
#(
    parameter int unsigned width   = 32,
    parameter int unsigned NUM_SRC = 8,
    localparam int unsigned ID_W   = $clog2(NUM_SRC)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_SRC-1:0]  irq_src,
    input  logic [1:0]          addr,
    input  logic                wr_en,
    input  logic [width-1:0]    wr_data,
    output logic [width-1:0]    rd_data,
    input  logic                TakenInterrupt,
    input  logic                ERET,
    output logic                irq_out,
    output logic [ID_W-1:0]     irq_id
);

    state_e              state_q;
    logic [ID_W-1:0]     irq_id_q;
    logic                irq_out_q;
    logic [NUM_SRC-1:0]  src_q;
    logic [NUM_SRC-1:0]  pending_q, pending_d;
    logic [NUM_SRC-1:0]  mask_q, mask_d;
    logic [NUM_SRC-1:0]  rise, w1c, take_clr;
    logic                elig_valid;
    logic [ID_W-1:0]     win_idx;
`ifdef IRQC_TIMER_EN
    logic [31:0]         count_q, count_d;
    logic [31:0]         compare_q, compare_d;
`endif

    logic unused_bits;
    assign unused_bits = ^{wr_data, src_q};

    // Pending/mask next state: a fresh edge beats both W1C and the take clear.
    always_comb begin
        rise = irq_src & ~src_q;
`ifdef IRQC_TIMER_EN
        rise[0] = (count_q == compare_q);
`endif
        w1c = '0;
        if (wr_en && addr == ADDR_PENDING) w1c = wr_data[NUM_SRC-1:0];
        take_clr = '0;
        if (state_q == REQ && TakenInterrupt) take_clr = NUM_SRC'(1) << irq_id_q;
        pending_d = (pending_q & ~w1c & ~take_clr) | rise;
        mask_d = mask_q;
        if (wr_en && addr == ADDR_MASK) mask_d = wr_data[NUM_SRC-1:0];
`ifdef IRQC_TIMER_EN
        count_d   = count_q + 32'd1;
        compare_d = compare_q;
        if (wr_en && addr == ADDR_COMPARE) begin
            compare_d = 32'(wr_data);
            count_d   = '0;
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            src_q     <= '0;
            pending_q <= '0;
            mask_q    <= '0;
`ifdef IRQC_TIMER_EN
            count_q   <= '0;
            compare_q <= '1;
`endif
        end else begin
            src_q     <= irq_src;
            pending_q <= pending_d;
            mask_q    <= mask_d;
`ifdef IRQC_TIMER_EN
            count_q   <= count_d;
            compare_q <= compare_d;
`endif
        end
    end

    prio_enc #(.N(NUM_SRC), .IW(ID_W)) u_prio (
        .req_i   (pending_q & mask_q),
        .valid_o (elig_valid),
        .idx_o   (win_idx)
    );

    // Request/take/return sequencing; irq_id is frozen outside IDLE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            irq_id_q  <= '0;
            irq_out_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (elig_valid) begin
                        state_q   <= REQ;
                        irq_id_q  <= win_idx;
                        irq_out_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (TakenInterrupt) begin
                        state_q   <= SERVICE;
                        irq_out_q <= 1'b0;
                    end else if (!(pending_q[irq_id_q] && mask_q[irq_id_q])) begin
                        state_q   <= IDLE;
                        irq_out_q <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (ERET) state_q <= IDLE;
                end
                default: begin
                    state_q   <= IDLE;
                    irq_out_q <= 1'b0;
                end
            endcase
        end
    end

    assign irq_out = irq_out_q;
    assign irq_id  = irq_id_q;

    always_comb begin
        rd_data = '0;
        case (addr)
            ADDR_PENDING: rd_data = width'(pending_q);
            ADDR_MASK:    rd_data = width'(mask_q);
            ADDR_STATUS:  rd_data = width'({state_q, irq_id_q});
`ifdef IRQC_TIMER_EN
            default:      rd_data = width'(compare_q);
`else
            default:      rd_data = '0;
`endif
        endcase
    end

endmodule

// File: doc/irq_controller.md
# irq_controller

Interrupt controller that sequences external interrupt requests into the coprocessor-0 block's single interrupt input. It latches rising edges from up to `NUM_SRC` sources into a pending register and applies a software mask. It selects the highest-priority eligible source, drives the cp0 interrupt line, and tracks the take/return handshake (`TakenInterrupt` / `ERET`). It sits beside cp0 and is programmed through a small register window.

## Interface
- `width`, 32, data width of the register window
- `NUM_SRC`, 8, number of interrupt sources (2..32); `ID_W = $clog2(NUM_SRC)`
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `irq_src`  in  NUM_SRC  level request lines; only rising edges are captured
- `addr`  in  2  register select for both read and write
- `wr_en`  in  1  write strobe for the `addr` register
- `wr_data`  in  width  write data
- `rd_data`  out  width  combinational read of the `addr` register
- `TakenInterrupt`  in  1  from cp0: interrupt accepted this cycle
- `ERET`  in  1  from cp0: return from exception this cycle
- `irq_out`  out  1  to cp0 `TimerInterrupt` input
- `irq_id`  out  ID_W  index of the source being requested or serviced

## Operation
- **Registers.**
  - addr 0 PENDING: write-1-to-clear.
  - addr 1 MASK: RW, 1 = enabled.
  - addr 2 STATUS: RO, `{0, state[1:0], irq_id}` with `irq_id` in the low bits.
  - addr 3 COMPARE: see Configuration; reads 0 when the timer is compiled out.
- **Edge capture.**
  - `irq_src` is registered into `src_q` every cycle.
  - `irq_src[i] & ~src_q[i]` at a clock edge sets `PENDING[i]`.
  - If a set and a W1C hit the same bit in the same cycle, the set wins.
- **Eligibility and priority.**
  - Eligible = `PENDING & MASK`.
  - Priority is fixed; the lowest index wins.
- **FSM states:** IDLE (0), REQ (1), SERVICE (2).
  - IDLE → REQ when eligible ≠ 0. `irq_id` latches the winning index.
  - REQ: `irq_out = 1` and `irq_id` is frozen, even if a higher-priority source arrives.
    - REQ → SERVICE on `TakenInterrupt`. `PENDING[irq_id]` is cleared on the same edge.
    - REQ → IDLE if `PENDING[irq_id] & MASK[irq_id]` goes to 0 through a software clear or mask.
    - `TakenInterrupt` wins over a simultaneous software clear.
  - SERVICE: `irq_out = 0`, `irq_id` held. SERVICE → IDLE on `ERET`.
  - `TakenInterrupt` seen in IDLE or SERVICE is ignored. `ERET` seen in IDLE or REQ is ignored.
- **Reset** (asynchronous, may occur in any state):
  - state = IDLE; PENDING, MASK and `src_q` = 0; `irq_id` = 0; `irq_out` = 0.
  - With the timer compiled in: COUNT = 0, COMPARE = all ones.
  - A source held high through reset release registers as an edge on the first clock after release.

## Timing
- Source rising edge sampled at edge k → PENDING visible after edge k.
  - If enabled: REQ and `irq_out` high after edge k+1, so request latency is 2 edges.
- `irq_out` is a registered state decode and has no combinational path from inputs.
- `TakenInterrupt` at edge t → `irq_out` low after t.
- `ERET` at edge e → IDLE after e. Another pending source can raise `irq_out` after e+1 at the earliest.
- Register writes take effect at the writing edge.
- MASK writes affect eligibility in the following cycle's FSM decision.

## Configuration
- `IRQC_TIMER_EN` defined:
  - 32-bit COUNT increments every cycle and wraps.
  - COUNT == COMPARE sets `PENDING[0]`; `irq_src[0]` is ignored.
  - A write to COMPARE also clears COUNT to 0.
- `IRQC_TIMER_EN` undefined:
  - No COUNT or COMPARE storage.
  - addr 3 reads 0 and ignores writes.
  - `irq_src[0]` is an ordinary source.

## Structure
- Package `irqc_pkg`: state enum (IDLE/REQ/SERVICE) and address constants (PENDING=0, MASK=1, STATUS=2, COMPARE=3).
- Sub-module `prio_enc`: parameterised lowest-index-first encoder producing `{valid, index}`.
- Everything else is in `irq_controller`.

## Test plan
- MASK=0x04; pulse `irq_src[2]` → `irq_out` high 2 edges later, `irq_id`=2; `TakenInterrupt` → `irq_out` low, PENDING=0x00, STATUS state=2; `ERET` → IDLE.
- MASK=0xFF; pulse sources 5 and 3 in the same cycle → `irq_id`=3. After take and `ERET`, `irq_id`=5 with `irq_out` high 2 edges after `ERET`.
- In REQ with `irq_id`=5, pulse source 1 → `irq_id` stays 5. Write PENDING W1C 0x20 → IDLE, then REQ with `irq_id`=1.
- Same-cycle `irq_src[4]` edge and W1C 0x10 → PENDING[4]=1. Hold `irq_src[4]` high for 10 cycles → only one edge captured.
- Assert `reset` mid-REQ (between clock edges) → `irq_out`=0, `rd_data` at addr 0/1/2 = 0 immediately.
- With `IRQC_TIMER_EN`: MASK=0x01, write COMPARE=10 → `irq_out` high 2 edges after COUNT reaches 10, `irq_id`=0. Without the macro: addr 3 reads 0 after writing 10.
